// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : uart_pkg                                               |
// | Description : Shared constants, FSM state encodings and helper       |
// |               functions for the UART receiver and transmitter.       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package uart_pkg;

  // Width of the clk-cycles-per-bit divisor.
  localparam int DIV_W = 24;

  // Data bits per frame = dataBits + DATA_BITS_OFFSET (5..8).
  localparam int DATA_BITS_OFFSET = 5;

  // Parity-mode encodings.
  localparam logic [1:0] PAR_SPACE = 2'b00;
  localparam logic [1:0] PAR_EVEN  = 2'b01;
  localparam logic [1:0] PAR_ODD   = 2'b10;
  localparam logic [1:0] PAR_MARK  = 2'b11;

  // Receiver FSM state encodings.
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_PARITY    = 3'd3;
  localparam logic [2:0] ST_STOP      = 3'd4;
  localparam logic [2:0] ST_WAIT_HIGH = 3'd5;

  // Parity bit a frame should carry; unused data bits must already be zero.
  function automatic logic expected_parity(input logic [1:0] mode,
                                           input logic [7:0] data);
    logic p;
    case (mode)
      PAR_SPACE: p = 1'b0;
      PAR_MARK:  p = 1'b1;
      PAR_EVEN:  p = ^data;
      default:   p = ~(^data);
    endcase
    return p;
  endfunction

  // Divisors below 2 cannot produce a half-bit point, so they are clamped.
  function automatic logic [DIV_W-1:0] eff_divisor(input logic [DIV_W-1:0] div);
    return (div < DIV_W'(2)) ? DIV_W'(2) : div;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_bit_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : uart_bit_timer                                         |
// | Description : Loadable down-counter producing the half-bit strobe    |
// |               (start-bit centre) and full-bit strobes (later bits).  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module uart_bit_timer
  import uart_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             enable_i,
  input  logic [DIV_W-1:0] divisor_i,
  output logic             half_stb_o,
  output logic             full_stb_o
);

  logic [DIV_W-1:0] cnt_q;
  logic             run_q;
  logic             half_q;
  logic [DIV_W-1:0] w_eff;
  logic [DIV_W-1:0] w_half;
  logic             w_stb;

  assign w_eff  = eff_divisor(divisor_i);
  assign w_half = w_eff >> 1;
  assign w_stb  = run_q && enable_i && (cnt_q == '0);

  assign half_stb_o = w_stb && half_q;
  assign full_stb_o = w_stb && !half_q;

  // Count down from half a bit after load, then reload a full bit per strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      run_q  <= 1'b0;
      half_q <= 1'b0;
    end else if (load_i) begin
      cnt_q  <= w_half - DIV_W'(1);
      run_q  <= 1'b1;
      half_q <= 1'b1;
    end else if (!enable_i) begin
      run_q  <= 1'b0;
    end else if (run_q) begin
      if (cnt_q == '0) begin
        cnt_q  <= w_eff - DIV_W'(1);
        half_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_q - DIV_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_transmitter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : uart_transmitter                                       |
// | Description : Companion UART transmitter sharing the receiver's      |
// |               configuration ports.                                   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module uart_transmitter
  import uart_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       dataBits,
  input  logic             hasParity,
  input  logic [1:0]       parityMode,
  input  logic             extraStopBit,
  input  logic [DIV_W-1:0] clockDivisor,
  input  logic [7:0]       txData,
  input  logic             txStart,
  output logic             tx,
  output logic             txBusy
);

  localparam logic [2:0] TX_IDLE   = 3'd0;
  localparam logic [2:0] TX_START  = 3'd1;
  localparam logic [2:0] TX_DATA   = 3'd2;
  localparam logic [2:0] TX_PARITY = 3'd3;
  localparam logic [2:0] TX_STOP   = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_q, par_d;
  logic             stop2_q, stop2_d;
  logic             tx_q, tx_d;

  logic [DIV_W-1:0] w_eff;
  logic [2:0]       w_last;
  logic [7:0]       w_mask;
  logic [7:0]       w_data;

  assign w_eff  = eff_divisor(clockDivisor);
  assign w_last = {1'b0, dataBits} + 3'(DATA_BITS_OFFSET - 1);
  assign w_mask = 8'hFF >> (2'd3 - dataBits);
  assign w_data = txData & w_mask;

  assign tx     = tx_q;
  assign txBusy = (state_q != TX_IDLE);

  // Next-state logic: each line level is held for one effective divisor.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    stop2_d = stop2_q;
    tx_d    = tx_q;
    if (state_q == TX_IDLE) begin
      tx_d = 1'b1;
      if (txStart) begin
        shift_d = w_data;
        par_d   = expected_parity(parityMode, w_data);
        cnt_d   = w_eff - DIV_W'(1);
        stop2_d = 1'b0;
        tx_d    = 1'b0;
        state_d = TX_START;
      end
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - DIV_W'(1);
    end else begin
      cnt_d = w_eff - DIV_W'(1);
      case (state_q)
        TX_START: begin
          state_d = TX_DATA;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
        end
        TX_DATA: begin
          if (bit_q == w_last) begin
            if (hasParity) begin
              state_d = TX_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = TX_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
        TX_PARITY: begin
          state_d = TX_STOP;
          tx_d    = 1'b1;
        end
        TX_STOP: begin
          if (extraStopBit && !stop2_q) begin
            stop2_d = 1'b1;
          end else begin
            state_d = TX_IDLE;
          end
        end
        default: state_d = TX_IDLE;
      endcase
    end
  end

  // Transmitter state registers; the line idles high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      par_q   <= 1'b0;
      stop2_q <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      stop2_q <= stop2_d;
      tx_q    <= tx_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : uart_rx_core                                           |
// | Description : UART receiver with synchronizer, configurable frame,   |
// |               parity check, break detection and a one-word holding  |
// |               register with overflow reporting.                      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module uart_rx_core
  import uart_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             rx,
  input  logic [1:0]       dataBits,
  input  logic             hasParity,
  input  logic [1:0]       parityMode,
  input  logic             extraStopBit,
  input  logic [DIV_W-1:0] clockDivisor,
  output logic [8:0]       dataOut,
  output logic             dataReceived,
  output logic             parityError,
  output logic             overflow,
  // "break" is a reserved word, hence the longer name.
  output logic             breakDetected,
  input  logic             receiveData
);

  logic       sync1_q, sync2_q;
  logic [1:0] settle_q;
  logic       armed_q;
  logic       rx_s;

  logic [2:0] state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] data_q, data_d;
  logic       par_q, par_d;

  logic [8:0] hold_q;
  logic       dr_q, pe_q, ov_q, brk_q;

  logic       w_load;
  logic       w_frame_ok;
  logic       w_break;
  logic       w_half_stb;
  logic       w_full_stb;
  logic       w_timer_en;
  logic [2:0] w_last;
  logic       w_perr;
  logic       unused_cfg;

  // The second stop bit is never sampled; the frame ends at the first one.
  assign unused_cfg = extraStopBit;

  assign rx_s       = sync2_q;
  assign w_last     = {1'b0, dataBits} + 3'(DATA_BITS_OFFSET - 1);
  assign w_timer_en = (state_q != ST_IDLE) && (state_q != ST_WAIT_HIGH);
  assign w_perr     = hasParity && (par_q != expected_parity(parityMode, data_q));

  assign dataOut       = hold_q;
  assign dataReceived  = dr_q;
  assign parityError   = pe_q;
  assign overflow      = ov_q;
  assign breakDetected = brk_q;

  // Two-flop synchronizer plus an arm flag so a start needs a prior high level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      settle_q <= 2'b00;
      armed_q  <= 1'b0;
    end else begin
      sync1_q  <= rx;
      sync2_q  <= sync1_q;
      settle_q <= {settle_q[0], 1'b1};
      if (w_load) begin
        armed_q <= 1'b0;
      end else if ((settle_q == 2'b11) && rx_s) begin
        armed_q <= 1'b1;
      end
    end
  end

  uart_bit_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (w_load),
    .enable_i   (w_timer_en),
    .divisor_i  (clockDivisor),
    .half_stb_o (w_half_stb),
    .full_stb_o (w_full_stb)
  );

  // Frame FSM: one sample per strobe, classification at the stop bit.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    data_d     = data_q;
    par_d      = par_q;
    w_load     = 1'b0;
    w_frame_ok = 1'b0;
    w_break    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (armed_q && !rx_s) begin
          state_d   = ST_START;
          w_load    = 1'b1;
          bit_cnt_d = 3'd0;
          data_d    = 8'd0;
          par_d     = 1'b0;
        end
      end
      ST_START: begin
        if (w_half_stb) begin
          state_d = rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_full_stb) begin
          data_d[bit_cnt_q] = rx_s;
          if (bit_cnt_q == w_last) begin
            state_d = hasParity ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (w_full_stb) begin
          par_d   = rx_s;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_full_stb) begin
          if (rx_s) begin
            w_frame_ok = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            w_break = (data_q == 8'd0) && !par_q;
            state_d = ST_WAIT_HIGH;
          end
        end
      end
      ST_WAIT_HIGH: begin
        if (rx_s) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and shift registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= 3'd0;
      data_q    <= 8'd0;
      par_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      data_q    <= data_d;
      par_q     <= par_d;
    end
  end

  // Holding register: acknowledge clears first, so a coincident frame is stored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q <= 9'd0;
      dr_q   <= 1'b0;
      pe_q   <= 1'b0;
      ov_q   <= 1'b0;
      brk_q  <= 1'b0;
    end else begin
      if (receiveData) begin
        dr_q  <= 1'b0;
        pe_q  <= 1'b0;
        ov_q  <= 1'b0;
        brk_q <= 1'b0;
      end
      if (w_frame_ok) begin
        if (!dr_q || receiveData) begin
          hold_q <= {par_q, data_q};
          dr_q   <= 1'b1;
          pe_q   <= w_perr;
        end else begin
          ov_q   <= 1'b1;
        end
      end
      if (w_break) begin
        brk_q <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_uart_rx_core                                        |
// | Description : Directed self-checking bench for uart_rx_core.         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_uart_rx_core;

  logic        clk;
  logic        rst;
  logic        rx;
  logic        rx_drv;
  logic        sel_tx;
  logic [1:0]  dataBits;
  logic        hasParity;
  logic [1:0]  parityMode;
  logic        extraStopBit;
  logic [23:0] clockDivisor;
  logic [8:0]  dataOut;
  logic        dataReceived;
  logic        parityError;
  logic        overflow;
  logic        breakDetected;
  logic        receiveData;
  logic [7:0]  txData;
  logic        txStart;
  logic        tx;
  logic        txBusy;

  int vectors;
  int miscompares;
  int waited;

  assign rx = sel_tx ? tx : rx_drv;

  uart_rx_core dut (
    .clk           (clk),
    .rst           (rst),
    .rx            (rx),
    .dataBits      (dataBits),
    .hasParity     (hasParity),
    .parityMode    (parityMode),
    .extraStopBit  (extraStopBit),
    .clockDivisor  (clockDivisor),
    .dataOut       (dataOut),
    .dataReceived  (dataReceived),
    .parityError   (parityError),
    .overflow      (overflow),
    .breakDetected (breakDetected),
    .receiveData   (receiveData)
  );

  uart_transmitter u_tx (
    .clk          (clk),
    .rst          (rst),
    .dataBits     (dataBits),
    .hasParity    (hasParity),
    .parityMode   (parityMode),
    .extraStopBit (extraStopBit),
    .clockDivisor (clockDivisor),
    .txData       (txData),
    .txStart      (txStart),
    .tx           (tx),
    .txBusy       (txBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic line(input logic v, input int n);
    rx_drv = v;
    repeat (n) @(negedge clk);
  endtask

  // Drive one frame: start, nb data bits LSB first, optional parity, stop bits.
  task automatic send_frame(input logic [7:0] d, input int nb, input logic hp,
                            input logic pb, input logic stopv, input int nstop,
                            input int bt);
    logic [7:0] b;
    b = d;
    line(1'b0, bt);
    for (int i = 0; i < nb; i++) line(b[i], bt);
    if (hp) line(pb, bt);
    for (int i = 0; i < nstop; i++) line(stopv, bt);
    line(1'b1, 2 * bt);
  endtask

  task automatic ack();
    receiveData = 1'b1;
    @(negedge clk);
    receiveData = 1'b0;
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    rst          = 1'b0;
    rx_drv       = 1'b1;
    sel_tx       = 1'b0;
    dataBits     = 2'd3;
    hasParity    = 1'b1;
    parityMode   = 2'b01;
    extraStopBit = 1'b0;
    clockDivisor = 24'd10;
    receiveData  = 1'b0;
    txData       = 8'h00;
    txStart      = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_dataOut", dataOut, 9'h000);
    check("rst_dataReceived", dataReceived, 9'd0);
    check("rst_parityError", parityError, 9'd0);
    check("rst_overflow", overflow, 9'd0);
    check("rst_break", breakDetected, 9'd0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // Loopback 0x60, 8 bits, even parity (bit 0), divisor 10
    sel_tx  = 1'b1;
    txData  = 8'h60;
    txStart = 1'b1;
    @(negedge clk);
    txStart = 1'b0;
    waited  = 1;
    while (!dataReceived && waited < 125) begin
      @(negedge clk);
      waited++;
    end
    check("lb_dataReceived", dataReceived, 9'd1);
    check("lb_dataOut", dataOut, 9'h060);
    check("lb_parityError", parityError, 9'd0);
    ack();
    check("lb_ack_clears", dataReceived, 9'd0);
    repeat (30) @(negedge clk);
    sel_tx = 1'b0;

    // 0x61 has three ones: even parity bit would be 1, line carries 0
    send_frame(8'h61, 8, 1'b1, 1'b0, 1'b1, 1, 10);
    check("perr_data", {1'b0, dataOut[7:0]}, 9'h061);
    check("perr_flag", parityError, 9'd1);
    check("perr_dr", dataReceived, 9'd1);
    ack();

    // Framing error: nonzero data with low stop bit -> silently discarded
    send_frame(8'h81, 8, 1'b1, 1'b0, 1'b0, 1, 10);
    check("frm_dr", dataReceived, 9'd0);
    check("frm_break", breakDetected, 9'd0);

    // Overflow: 0x12 (parity 0) then 0x34 (parity 1), no acknowledge
    send_frame(8'h12, 8, 1'b1, 1'b0, 1'b1, 1, 10);
    send_frame(8'h34, 8, 1'b1, 1'b1, 1'b1, 1, 10);
    check("ovf_data", dataOut, 9'h012);
    check("ovf_flag", overflow, 9'd1);
    check("ovf_dr", dataReceived, 9'd1);
    ack();
    check("ovf_ack_dr", dataReceived, 9'd0);
    check("ovf_ack_ov", overflow, 9'd0);

    // Break: line low for 15 bit times
    line(1'b0, 150);
    line(1'b1, 30);
    check("brk_flag", breakDetected, 9'd1);
    check("brk_dr", dataReceived, 9'd0);
    send_frame(8'h55, 8, 1'b1, 1'b0, 1'b1, 1, 10);
    check("brk_next_data", dataOut, 9'h055);
    check("brk_next_dr", dataReceived, 9'd1);
    check("brk_held", breakDetected, 9'd1);
    ack();
    check("brk_ack", breakDetected, 9'd0);

    // 100-cycle glitch at divisor 1000 is a false start
    clockDivisor = 24'd1000;
    line(1'b0, 100);
    line(1'b1, 700);
    check("glitch_dr", dataReceived, 9'd0);
    check("glitch_break", breakDetected, 9'd0);
    check("glitch_perr", parityError, 9'd0);
    clockDivisor = 24'd10;
    send_frame(8'h3C, 8, 1'b1, 1'b0, 1'b1, 1, 10);
    check("glitch_next", dataOut, 9'h03C);
    ack();

    // Divisor 1 behaves as 2 cycles per bit; two stop bits on the line
    clockDivisor = 24'd1;
    extraStopBit = 1'b1;
    send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b1, 2, 2);
    check("div1_data", dataOut, 9'h0A5);
    check("div1_dr", dataReceived, 9'd1);
    ack();
    clockDivisor = 24'd10;
    extraStopBit = 1'b0;

    // 5 data bits, mark parity
    dataBits   = 2'd0;
    parityMode = 2'b11;
    send_frame(8'h1F, 5, 1'b1, 1'b1, 1'b1, 1, 10);
    check("m5_data", dataOut, 9'h11F);
    check("m5_perr", parityError, 9'd0);
    ack();

    // Reset mid-frame with the line held low through and after release
    line(1'b0, 25);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_rst_dataOut", dataOut, 9'h000);
    check("mid_rst_dr", dataReceived, 9'd0);
    rst = 1'b1;
    line(1'b0, 300);
    check("post_rst_break", breakDetected, 9'd0);
    check("post_rst_dr", dataReceived, 9'd0);
    line(1'b1, 30);
    send_frame(8'h0A, 5, 1'b1, 1'b1, 1'b1, 1, 10);
    check("post_rst_frame", dataOut, 9'h10A);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have rst  in  1  asynchronous, active-low reset.
REQ-003 SHALL have rx  in  1  serial line, idle high, asynchronous to clk.
REQ-004 SHALL have dataBits  in  2  data bits per frame = dataBits+5 (5..8).
REQ-005 SHALL have hasParity  in  1  1 = parity bit follows the data bits.
REQ-006 SHALL have parityMode  in  2  00 space (0), 11 mark (1), 01 even, 10 odd.
REQ-007 SHALL have extraStopBit  in  1  1 = two stop bits per frame.
REQ-008 SHALL have clockDivisor  in  24  clk cycles per bit.
REQ-009 SHALL have dataOut  out  9  [7:0] data, LSB = first bit received, unused upper bits 0; [8] = received parity bit, 0 when hasParity=0.
REQ-010 SHALL have dataReceived  out  1  holding register valid.
REQ-011 SHALL have parityError  out  1  parity mismatch on the held word.
REQ-012 SHALL have overflow  out  1  a frame was lost while dataReceived=1.
REQ-013 SHALL have break  out  1  break condition detected.
REQ-014 SHALL have receiveData  in  1  one-cycle read acknowledge.
REQ-015 Configuration inputs SHALL be held stable while a frame is in progress; changes take effect at the next start bit.

Function
REQ-016 rx SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value.
REQ-017 FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
REQ-018 IDLE -> START on a synchronized high-to-low rx transition.
REQ-019 START: after floor(clockDivisor/2) cycles, rx sampled; low -> DATA, high -> IDLE (false start, no flags).
REQ-020 Each later bit SHALL be sampled exactly clockDivisor cycles after the previous sample (mid-bit).
REQ-021 An effective clockDivisor below 2 SHALL be treated as 2.
REQ-022 DATA shifts in dataBits+5 bits LSB-first, then goes to PARITY if hasParity=1, else to STOP.
REQ-023 Expected parity: space=0, mark=1, even = XOR of data bits, odd = its inverse; a mismatch flags parityError.
REQ-024 STOP samples only the first stop bit; extraStopBit SHALL NOT be checked by the receiver.
REQ-025 Stop high = valid frame: data, parity bit and parityError SHALL be loaded into the holding register, and dataReceived SHALL be set within 3 clk of the stop sample.
REQ-026 Stop low and all data/parity bits 0 = break: break SHALL be set, nothing stored, next state WAIT_HIGH.
REQ-027 Stop low with any nonzero bit = framing error: frame discarded, no flag, next state WAIT_HIGH.
REQ-028 WAIT_HIGH -> IDLE once synchronized rx is high.
REQ-029 Valid frame completing while dataReceived=1: new frame discarded, held word unchanged, overflow set.
REQ-030 receiveData=1 for one cycle SHALL clear dataReceived, parityError, overflow and break on the next edge.
REQ-031 receiveData while dataReceived=0 SHALL clear flags only, with no other effect.
REQ-032 If receiveData and frame completion coincide, the acknowledge SHALL apply first; the new frame is stored with no overflow.
REQ-033 The FSM SHALL run independently of the holding register; reception SHALL continue while a word is held.

Reset
REQ-034 While rst=0: FSM in IDLE; synchronizer flops at 1; dataOut=0; dataReceived, parityError, overflow and break all 0.
REQ-035 Reset asserted mid-frame SHALL abort the frame with no flags; after release, a start bit is accepted only after rx has been seen high.

Structure
REQ-036 A shared package uart_pkg SHALL hold the parity-mode encodings, the FSM state enum, the divisor width (24) and the data-bits offset (5).
REQ-037 Companion module uart_transmitter SHALL use the same config ports and uart_pkg.
REQ-038 One sub-module, uart_bit_timer, SHALL be used: a loadable 24-bit down-counter emitting the half-bit and full-bit sample strobes.

Verification
REQ-039 Loopback from uart_transmitter, divisor 10, 8 bits, even parity, 1 stop, byte 0x60 -> dataReceived=1 within 125 clk of start, dataOut=9'h060, parityError=0; one receiveData pulse -> dataReceived=0 next cycle.
REQ-040 Same setup, byte 0x61 with odd parity forced on the line -> dataOut[7:0]=0x61, parityError=1.
REQ-041 Two frames (0x12, then 0x34) with no acknowledge -> dataOut[7:0]=0x12, overflow=1; receiveData clears both flags.
REQ-042 rx held low for 15 bit times -> break=1, dataReceived=0; rx high then frame 0x55 -> received correctly.
REQ-043 100-cycle low glitch at divisor 1000 -> no flags, FSM back in IDLE.
REQ-044 5 data bits, mark parity, 0x1F -> dataOut=9'h11F; rst asserted mid-frame -> all outputs 0.
